// File: rtl/sdr_pkg.sv
// Shared constants for the x2 compensating interpolator:
// coefficient table, FSM states and accumulator sizing.
package sdr_pkg;

   localparam int RND_SHIFT = 17;
   localparam int NTAPS     = 32;

   typedef enum logic [1:0] {IDLE, LOAD, MAC, ROUND} state_t;

   // Symmetric 32-tap set; each polyphase branch sums to 2^17
   localparam logic signed [17:0] H [NTAPS] = '{
      -18'sd120,   -18'sd110,   18'sd350,    18'sd330,
      -18'sd780,   -18'sd750,   18'sd1520,   18'sd1500,
      -18'sd2720,  -18'sd2800,  18'sd4700,   18'sd5200,
      -18'sd8450,  -18'sd11000, 18'sd29202,  18'sd115000,
      18'sd115000, 18'sd29202,  -18'sd11000, -18'sd8450,
      18'sd5200,   18'sd4700,   -18'sd2800,  -18'sd2720,
      18'sd1500,   18'sd1520,   -18'sd750,   -18'sd780,
      18'sd330,    18'sd350,    -18'sd110,   -18'sd120
   };

   function automatic int acc_bits(input int ib, input int cb,
                                   input int nph);
      return ib + cb + $clog2(nph) + 1;
   endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// One lane of the interpolator: circular delay line,
// multiply-accumulate, and round/saturate into the result register.
module fir_mac_lane
   import sdr_pkg::*;
#(
   parameter int IBITS = 20,
   parameter int OBITS = 20,
   parameter int CBITS = 18,
   parameter int NPH   = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [$clog2(NPH)-1:0]   wr_addr,
   input  logic [$clog2(NPH)-1:0]   rd_addr,
   input  logic signed [IBITS-1:0]  wr_data,
   input  logic signed [CBITS-1:0]  coef,
   input  logic                     clr,
   input  logic                     mac_en,
   input  logic                     rnd_en,
   output logic signed [OBITS-1:0]  result
);

   localparam int AB = acc_bits(IBITS, CBITS, NPH);
   localparam int PB = IBITS + CBITS;
   localparam logic signed [AB-1:0] HALF = AB'(1) << (RND_SHIFT - 1);

   logic signed [IBITS-1:0] dly [NPH];
   logic signed [PB-1:0]    prod;
   logic signed [AB-1:0]    acc;
   logic signed [AB-1:0]    rnd;
   logic signed [AB-1:0]    shr;
   logic [AB-OBITS:0]       top;
   logic signed [OBITS-1:0] sat;

   assign prod = dly[rd_addr] * coef;
   assign rnd  = acc + HALF;
   assign shr  = rnd >>> RND_SHIFT;
   assign top  = shr[AB-1:OBITS-1];

   // Clamp when the bits above the output sign are not a sign copy
   always_comb begin
      sat = shr[OBITS-1:0];
      if (!(&top) && (|top)) begin
         if (shr[AB-1])
            sat = {1'b1, {(OBITS-1){1'b0}}};
         else
            sat = {1'b0, {(OBITS-1){1'b1}}};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NPH; i++)
            dly[i] <= '0;
         acc    <= '0;
         result <= '0;
      end else begin
         if (wr_en)
            dly[wr_addr] <= wr_data;
         if (clr)
            acc <= '0;
         else if (mac_en)
            acc <= acc + AB'(prod);
         if (rnd_en)
            result <= sat;
      end
   end

endmodule

// File: rtl/fir_interp2_comp.sv
// x2 polyphase FIR interpolator feeding the CIC: sequencing FSM,
// write pointer, phase tracking and CIC/upstream handshakes.
module fir_interp2_comp
   import sdr_pkg::*;
#(
   parameter int IBITS = 20,
   parameter int OBITS = 20,
   parameter int CBITS = 18,
   parameter int NPH   = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cic_req,
   output logic              in_req,
   input  logic [IBITS-1:0]  x_real,
   input  logic [IBITS-1:0]  x_imag,
   output logic [OBITS-1:0]  y_real,
   output logic [OBITS-1:0]  y_imag,
   output logic              overrun
);

   localparam int AW = $clog2(NPH);

   state_t                  state, state_n;
   logic [AW-1:0]           wptr;
   logic [AW-1:0]           tap;
   logic [AW-1:0]           rd_addr;
   logic                    nphase;
   logic                    busy;
   logic                    start;
   logic                    clr;
   logic                    mac_en;
   logic                    rnd_en;
   logic signed [CBITS-1:0] coef;
   logic signed [OBITS-1:0] res_r, res_i;

   assign busy    = (state != IDLE);
   assign rd_addr = wptr - AW'(1) - tap;
   assign coef    = H[{tap, nphase}];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         wptr    <= '0;
         tap     <= '0;
         nphase  <= 1'b0;
         overrun <= 1'b0;
         y_real  <= '0;
         y_imag  <= '0;
      end else begin
         state <= state_n;
         if (cic_req && busy)
            overrun <= 1'b1;
         if (start) begin
            y_real <= res_r;
            y_imag <= res_i;
         end
         if (clr)
            tap <= '0;
         else if (mac_en)
            tap <= tap + 1'b1;
         if (in_req)
            wptr <= wptr + 1'b1;
         if (rnd_en)
            nphase <= ~nphase;
      end
   end

   always_comb begin
      state_n = state;
      start   = 1'b0;
      in_req  = 1'b0;
      clr     = 1'b0;
      mac_en  = 1'b0;
      rnd_en  = 1'b0;
      unique case (state)
         IDLE: begin
            if (cic_req) begin
               start   = 1'b1;
               state_n = LOAD;
            end
         end
         LOAD: begin
            clr     = 1'b1;
            in_req  = ~nphase;
            state_n = MAC;
         end
         MAC: begin
            mac_en = 1'b1;
            if (tap == AW'(NPH - 1))
               state_n = ROUND;
         end
         ROUND: begin
            rnd_en  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   fir_mac_lane #(
      .IBITS(IBITS), .OBITS(OBITS), .CBITS(CBITS), .NPH(NPH)
   ) u_lane_r (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (in_req),
      .wr_addr (wptr),
      .rd_addr (rd_addr),
      .wr_data (x_real),
      .coef    (coef),
      .clr     (clr),
      .mac_en  (mac_en),
      .rnd_en  (rnd_en),
      .result  (res_r)
   );

   fir_mac_lane #(
      .IBITS(IBITS), .OBITS(OBITS), .CBITS(CBITS), .NPH(NPH)
   ) u_lane_i (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (in_req),
      .wr_addr (wptr),
      .rd_addr (rd_addr),
      .wr_data (x_imag),
      .coef    (coef),
      .clr     (clr),
      .mac_en  (mac_en),
      .rnd_en  (rnd_en),
      .result  (res_i)
   );

endmodule

// File: tb/tb_fir_interp2_comp.sv
// Scoreboard bench for fir_interp2_comp: a reference polyphase model
// predicts every y, and the DUT output is compared after each request.
module tb_fir_interp2_comp;
   import sdr_pkg::*;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               cic_req = 1'b0;
   logic               in_req;
   logic signed [19:0] x_real = '0;
   logic signed [19:0] x_imag = '0;
   logic signed [19:0] y_real;
   logic signed [19:0] y_imag;
   logic               overrun;

   int total = 0;
   int bad = 0;
   int inreq_cnt = 0;

   longint m_buf_r [16];
   longint m_buf_i [16];
   int     m_wp;
   int     m_ph;
   longint m_res_r, m_res_i;
   longint exp_r [$];
   longint exp_i [$];

   fir_interp2_comp dut (
      .clock   (clock),
      .reset   (reset),
      .cic_req (cic_req),
      .in_req  (in_req),
      .x_real  (x_real),
      .x_imag  (x_imag),
      .y_real  (y_real),
      .y_imag  (y_imag),
      .overrun (overrun)
   );

   always #5 clock = ~clock;

   always @(negedge clock)
      if (in_req === 1'b1)
         inreq_cnt++;

   function automatic longint model_fir(input longint b [16],
                                        input int wp, input int ph);
      longint acc = 0;
      longint q;
      for (int k = 0; k < 16; k++)
         acc += longint'(H[2*k+ph]) * b[(wp - 1 - k + 16) % 16];
      q = (acc + 65536) >>> 17;
      if (q > 524287)
         q = 524287;
      if (q < -524288)
         q = -524288;
      return q;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin
         m_buf_r[i] = 0;
         m_buf_i[i] = 0;
      end
      m_wp = 0;
      m_ph = 0;
      m_res_r = 0;
      m_res_i = 0;
      exp_r.delete();
      exp_i.delete();
   endtask

   task automatic model_req(input longint xr, input longint xi);
      exp_r.push_back(m_res_r);
      exp_i.push_back(m_res_i);
      if (m_ph == 0) begin
         m_buf_r[m_wp] = xr;
         m_buf_i[m_wp] = xi;
         m_wp = (m_wp + 1) % 16;
      end
      m_res_r = model_fir(m_buf_r, m_wp, m_ph);
      m_res_i = model_fir(m_buf_i, m_wp, m_ph);
      m_ph = 1 - m_ph;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cic_req = 1'b0;
      x_real = '0;
      x_imag = '0;
      m_reset();
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   // Starts and ends on a falling edge; sp is the request spacing
   task automatic req(input logic signed [19:0] xr,
                      input logic signed [19:0] xi, input int sp);
      longint er, ei;
      logic   eq;
      eq = (m_ph == 0);
      x_real = xr;
      x_imag = xi;
      cic_req = 1'b1;
      model_req(longint'(xr), longint'(xi));
      @(negedge clock);
      cic_req = 1'b0;
      total++;
      if (exp_r.size() == 0) begin
         bad++;
         $display("FAIL scoreboard_empty got=%0d want=1", exp_r.size());
      end else begin
         er = exp_r.pop_front();
         ei = exp_i.pop_front();
         total++;
         if (y_real !== 20'(er)) begin
            bad++;
            $display("FAIL y_real got=%0d want=%0d", y_real, er);
         end
         total++;
         if (y_imag !== 20'(ei)) begin
            bad++;
            $display("FAIL y_imag got=%0d want=%0d", y_imag, ei);
         end
      end
      total++;
      if (in_req !== eq) begin
         bad++;
         $display("FAIL in_req_load got=%b want=%b", in_req, eq);
      end
      repeat (sp - 1) @(negedge clock);
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (y_real !== 20'sd0 || y_imag !== 20'sd0) begin
         bad++;
         $display("FAIL reset_y got=%0d/%0d want=0/0", y_real, y_imag);
      end
      total++;
      if (in_req !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags got=%b%b want=00", in_req, overrun);
      end
   endtask

   task automatic test_impulse();
      int want;
      do_reset();
      for (int i = 0; i < 34; i++) begin
         req((i == 0) ? 20'sd262144 : 20'sd0, 20'sd0, 20);
         want = (i >= 1 && i <= 32) ? 2 * int'(H[i-1]) : 0;
         total++;
         if (y_real !== 20'(want)) begin
            bad++;
            $display("FAIL impulse_%0d got=%0d want=%0d", i, y_real, want);
         end
         total++;
         if (y_imag !== 20'sd0) begin
            bad++;
            $display("FAIL impulse_imag_%0d got=%0d want=0", i, y_imag);
         end
      end
   endtask

   task automatic test_dc();
      do_reset();
      for (int i = 0; i < 40; i++) begin
         req(20'sd100000, -20'sd100000, 19);
         if (i >= 33) begin
            total++;
            if (y_real !== 20'sd100000 || y_imag !== -20'sd100000) begin
               bad++;
               $display("FAIL dc_%0d got=%0d/%0d want=100000/-100000",
                        i, y_real, y_imag);
            end
         end
      end
   endtask

   task automatic test_saturation();
      int nclamp = 0;
      logic signed [19:0] v;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         v = ((i / 2) % 2 == 1) ? -20'sd524288 : 20'sd524287;
         req(v, -v - 20'sd1, 19);
      end
      for (int i = 0; i < 72; i++) begin
         v = (((i / 2) / 9) % 2 == 1) ? -20'sd524288 : 20'sd524287;
         req(v, -v - 20'sd1, 19);
         if (y_real == 20'sd524287 || y_real == -20'sd524288)
            nclamp++;
      end
      total++;
      if (nclamp == 0) begin
         bad++;
         $display("FAIL sat_clamped got=%0d want=>0", nclamp);
      end
   endtask

   task automatic test_overrun();
      longint er, ei;
      logic signed [19:0] yh;
      do_reset();
      for (int i = 0; i < 4; i++)
         req(20'sd100000, -20'sd50000, 19);
      x_real = 20'sd300000;
      x_imag = 20'sd7;
      cic_req = 1'b1;
      model_req(300000, 7);
      @(negedge clock);
      cic_req = 1'b0;
      er = exp_r.pop_front();
      ei = exp_i.pop_front();
      total++;
      if (y_real !== 20'(er) || y_imag !== 20'(ei)) begin
         bad++;
         $display("FAIL ovr_first got=%0d/%0d want=%0d/%0d",
                  y_real, y_imag, er, ei);
      end
      yh = y_real;
      repeat (4) @(negedge clock);
      cic_req = 1'b1;
      @(negedge clock);
      cic_req = 1'b0;
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_set got=%b want=1", overrun);
      end
      total++;
      if (y_real !== yh) begin
         bad++;
         $display("FAIL ovr_y_hold got=%0d want=%0d", y_real, yh);
      end
      repeat (14) @(negedge clock);
      for (int i = 0; i < 3; i++)
         req(20'sd300000, 20'sd7, 19);
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_sticky got=%b want=1", overrun);
      end
   endtask

   task automatic test_back_to_back();
      logic signed [19:0] r, s;
      do_reset();
      inreq_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         r = 20'($urandom);
         s = 20'($urandom);
         req(r, s, 19);
      end
      total++;
      if (inreq_cnt != 100) begin
         bad++;
         $display("FAIL inreq_count got=%0d want=100", inreq_cnt);
      end
   endtask

   task automatic test_reset_mid_mac();
      do_reset();
      for (int i = 0; i < 20; i++)
         req(20'sd100000, -20'sd100000, 19);
      x_real = 20'sd5;
      x_imag = 20'sd5;
      cic_req = 1'b1;
      @(negedge clock);
      cic_req = 1'b0;
      repeat (2) @(negedge clock);
      cic_req = 1'b1;
      @(negedge clock);
      cic_req = 1'b0;
      repeat (5) @(negedge clock);
      reset = 1'b1;
      #1;
      total++;
      if (y_real !== 20'sd0 || y_imag !== 20'sd0) begin
         bad++;
         $display("FAIL midrst_y got=%0d/%0d want=0/0", y_real, y_imag);
      end
      total++;
      if (in_req !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL midrst_flags got=%b%b want=00", in_req, overrun);
      end
      m_reset();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      req(20'sd1234, -20'sd4321, 19);
      total++;
      if (y_real !== 20'sd0) begin
         bad++;
         $display("FAIL midrst_first got=%0d want=0", y_real);
      end
      req(20'sd0, 20'sd0, 19);
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_dc();
      test_saturation();
      test_overrun();
      test_back_to_back();
      test_reset_mid_mac();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
